// File: rtl/mdr_pkg.sv
// ============================================================================
// mdr_pkg
// Shared definitions for the MDR host sequencer:
//   - operation encodings presented on req_op / mdr_op
//   - error encodings returned on rsp_err
//   - sequencer state encoding
//   - small helpers used when sizing and decoding
// ============================================================================
package mdr_pkg;

    // Operation encodings understood by the MDR unit
    localparam logic [1:0] OP_DIV     = 2'b00;
    localparam logic [1:0] OP_MUL     = 2'b01;
    localparam logic [1:0] OP_SQRT    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // Response error encodings
    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_OP      = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Sequencer states, in the order an operation walks through them
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_X  = 4'd1,
        ST_GAP_X   = 4'd2,
        ST_LOAD_Y  = 4'd3,
        ST_GAP_S   = 4'd4,
        ST_START   = 4'd5,
        ST_BLANK   = 4'd6,
        ST_WAIT    = 4'd7,
        ST_CAPTURE = 4'd8,
        ST_RESP    = 4'd9
    } mdr_state_e;

    // Largest of three integers, used to size the shared phase counter
    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // True for the three operations the MDR unit actually implements
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_MUL) || (op == OP_SQRT);
    endfunction

endpackage

// File: rtl/mdr_seq_counter.sv
// ============================================================================
// mdr_seq_counter
// Loadable down-counter that times the gap, blanking and timeout phases of
// the sequencer. A phase lasting N cycles is started by loading N-1; the
// phase ends in the cycle where zero is high. Counting stops at zero.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset (count returns to 0)
//   load       in   load load_value on the next clock edge
//   load_value in   value to load
//   zero       out  count is zero
// ============================================================================
module mdr_seq_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load wins over counting; otherwise decrement and saturate at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mdr_host_sequencer.sv
// ============================================================================
// mdr_host_sequencer
// Initiator-side driver for the MDR multiply/divide/square-root unit. One
// request is accepted on a valid/ready handshake, its operands are strobed
// onto the shared MDR data bus with mdr_loadctl, the unit is started and
// its ready level awaited, and the captured result is returned on a
// valid/ready response channel. Illegal ops and timeouts are reported on
// rsp_err without waiting for MDR.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_op, req_a, req_b operation and operands
//   rsp_valid/rsp_ready  response handshake
//   rsp_result, rsp_rem, rsp_sign, rsp_err   response payload
//   mdr_op, mdr_data, mdr_loadctl, mdr_start  drive side of the MDR unit
//   mdr_ready, mdr_result, mdr_reminder, mdr_sign  MDR status/results
// ============================================================================
module mdr_host_sequencer
    import mdr_pkg::*;
#(
    parameter int LOAD_GAP    = 1,
    parameter int READY_BLANK = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_rem,
    output logic        rsp_sign,
    output logic [1:0]  rsp_err,
    output logic [1:0]  mdr_op,
    output logic [15:0] mdr_data,
    output logic        mdr_loadctl,
    output logic        mdr_start,
    input  logic        mdr_ready,
    input  logic [31:0] mdr_result,
    input  logic [31:0] mdr_reminder,
    input  logic        mdr_sign
);

    localparam logic [3:0] S_IDLE    = ST_IDLE;
    localparam logic [3:0] S_LOAD_X  = ST_LOAD_X;
    localparam logic [3:0] S_GAP_X   = ST_GAP_X;
    localparam logic [3:0] S_LOAD_Y  = ST_LOAD_Y;
    localparam logic [3:0] S_GAP_S   = ST_GAP_S;
    localparam logic [3:0] S_START   = ST_START;
    localparam logic [3:0] S_BLANK   = ST_BLANK;
    localparam logic [3:0] S_WAIT    = ST_WAIT;
    localparam logic [3:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [3:0] S_RESP    = ST_RESP;

    // One counter serves every timed phase, so it is sized for the longest.
    localparam int CNT_MAX = max_of3(TIMEOUT, LOAD_GAP, READY_BLANK);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Phases of N cycles load N-1; a zero-length setting still costs one cycle.
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'((LOAD_GAP    > 0) ? LOAD_GAP    - 1 : 0);
    localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'((READY_BLANK > 0) ? READY_BLANK - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT     > 0) ? TIMEOUT     - 1 : 0);

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic [15:0]      b_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             accept;

    assign accept = (state == S_IDLE) && req_valid;

    // Next-state logic. The square-root path skips the second operand load
    // and goes straight from the first gap to the pre-start gap. In WAIT a
    // ready seen in the final timeout cycle still counts as success.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (req_valid) next_state = op_is_legal(req_op) ? S_LOAD_X : S_RESP;
            S_LOAD_X:  next_state = S_GAP_X;
            S_GAP_X:   if (cnt_zero) next_state = (mdr_op == OP_SQRT) ? S_GAP_S : S_LOAD_Y;
            S_LOAD_Y:  next_state = S_GAP_S;
            S_GAP_S:   if (cnt_zero) next_state = S_START;
            S_START:   next_state = S_BLANK;
            S_BLANK:   if (cnt_zero) next_state = S_WAIT;
            S_WAIT: begin
                if (mdr_ready)     next_state = S_CAPTURE;
                else if (cnt_zero) next_state = S_RESP;
            end
            S_CAPTURE: next_state = S_RESP;
            S_RESP:    if (rsp_ready) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // The phase counter is reloaded on every state change with the length
    // of the phase being entered; states that are not timed ignore it.
    always_comb begin
        cnt_load  = (next_state != state);
        cnt_value = GAP_LOAD;
        case (next_state)
            S_BLANK: cnt_value = BLANK_LOAD;
            S_WAIT:  cnt_value = TIMEOUT_LOAD;
            default: cnt_value = GAP_LOAD;
        endcase
    end

    mdr_seq_counter #(
        .WIDTH(CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(cnt_value),
        .zero      (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand and op registers. An illegal op never reaches MDR, so it does
    // not disturb mdr_op or the bus. The first operand goes on the bus at
    // acceptance so it is present during LOAD_X; the second replaces it
    // only when LOAD_Y is entered, keeping the bus steady through GAP_X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdr_op   <= OP_DIV;
            mdr_data <= '0;
            b_q      <= '0;
        end else begin
            if (accept && op_is_legal(req_op)) begin
                mdr_op   <= req_op;
                mdr_data <= req_a;
                b_q      <= req_b;
            end
            if ((state == S_GAP_X) && (next_state == S_LOAD_Y)) begin
                mdr_data <= b_q;
            end
        end
    end

    // Response payload. Results are sampled at the end of CAPTURE, one
    // cycle after ready, so MDR's output registers have settled. The
    // payload is only written on entry to RESP, so it stays stable while
    // the consumer applies back-pressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_rem    <= '0;
            rsp_sign   <= 1'b0;
            rsp_err    <= ERR_OK;
        end else if (accept && !op_is_legal(req_op)) begin
            rsp_result <= '0;
            rsp_rem    <= '0;
            rsp_sign   <= 1'b0;
            rsp_err    <= ERR_OP;
        end else if ((state == S_WAIT) && (next_state == S_RESP)) begin
            rsp_result <= '0;
            rsp_rem    <= '0;
            rsp_sign   <= 1'b0;
            rsp_err    <= ERR_TIMEOUT;
        end else if (state == S_CAPTURE) begin
            rsp_result <= mdr_result;
            rsp_rem    <= mdr_reminder;
            rsp_sign   <= mdr_sign;
            rsp_err    <= ERR_OK;
        end
    end

    // Strobes and handshakes decode straight from the state register, so an
    // asynchronous reset drops them immediately and each is one cycle wide.
    assign mdr_loadctl = (state == S_LOAD_X) || (state == S_LOAD_Y);
    assign mdr_start   = (state == S_START);
    assign req_ready   = (state == S_IDLE);
    assign rsp_valid   = (state == S_RESP);

endmodule

// File: tb/tb_mdr_host_sequencer.sv
// ============================================================================
// tb_mdr_host_sequencer
// Directed bench for mdr_host_sequencer with a small behavioural MDR model.
// The model has three modes: 0 normal (drops ready on start, raises it with
// results three cycles later), 1 ready stuck low, 2 ready stuck high.
// ============================================================================
module tb_mdr_host_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result, rsp_rem;
    logic        rsp_sign;
    logic [1:0]  rsp_err;
    logic [1:0]  mdr_op;
    logic [15:0] mdr_data;
    logic        mdr_loadctl, mdr_start;
    logic        mdr_ready = 1'b1;
    logic [31:0] mdr_result = '0;
    logic [31:0] mdr_reminder = '0;
    logic        mdr_sign = 1'b0;

    mdr_host_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_rem     (rsp_rem),
        .rsp_sign    (rsp_sign),
        .rsp_err     (rsp_err),
        .mdr_op      (mdr_op),
        .mdr_data    (mdr_data),
        .mdr_loadctl (mdr_loadctl),
        .mdr_start   (mdr_start),
        .mdr_ready   (mdr_ready),
        .mdr_result  (mdr_result),
        .mdr_reminder(mdr_reminder),
        .mdr_sign    (mdr_sign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor/model state, written only by the monitor process
    int          cyc = 0;
    int          load_cnt = 0;
    int          start_cnt = 0;
    int          overlap = 0;
    int          start_cyc = 0;
    int          rsp_cyc = 0;
    int          rsp_rise_cnt = 0;
    int          lat_cnt = 0;
    logic        prev_rsp = 1'b0;
    logic [15:0] load_data [64];

    // Test-side state, written only by the test tasks
    int          model_mode = 0;
    logic [31:0] model_result = '0;
    logic [31:0] model_rem = '0;
    logic        model_sign = 1'b0;
    int          acc_cyc = 0;
    int          base_load = 0;
    int          base_start = 0;
    int          base_rise = 0;

    // Sample just after each rising edge, then update the MDR model.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mdr_loadctl) begin
            load_data[load_cnt % 64] = mdr_data;
            load_cnt = load_cnt + 1;
        end
        if (mdr_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (mdr_loadctl && mdr_start) overlap = overlap + 1;
        if (rsp_valid && !prev_rsp) begin
            rsp_rise_cnt = rsp_rise_cnt + 1;
            rsp_cyc = cyc;
        end
        prev_rsp = rsp_valid;
        case (model_mode)
            1: begin
                mdr_ready = 1'b0;
                mdr_result = model_result; mdr_reminder = model_rem; mdr_sign = model_sign;
            end
            2: begin
                mdr_ready = 1'b1;
                mdr_result = model_result; mdr_reminder = model_rem; mdr_sign = model_sign;
            end
            default: begin
                if (mdr_start) begin
                    mdr_ready = 1'b0;
                    lat_cnt = 3;
                    mdr_result = 32'hDEAD_BEEF; mdr_reminder = 32'hDEAD_BEEF;
                end else if (lat_cnt > 0) begin
                    lat_cnt = lat_cnt - 1;
                    if (lat_cnt == 0) begin
                        mdr_ready = 1'b1;
                        mdr_result = model_result; mdr_reminder = model_rem; mdr_sign = model_sign;
                    end
                end
            end
        endcase
    end

    // Present a request and return just after the accepting edge.
    task automatic send_request(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output bit ok);
        ok = 1'b0;
        @(negedge clk);
        base_load  = load_cnt;
        base_start = start_cnt;
        base_rise  = rsp_rise_cnt;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #2;
            acc_cyc = cyc - 1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_response(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 2'b00; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (mdr_loadctl !== 1'b0) begin bad++; $display("[TB] FAIL rst_loadctl got=%0b exp=0", mdr_loadctl); end
        total++; if (mdr_start !== 1'b0) begin bad++; $display("[TB] FAIL rst_start got=%0b exp=0", mdr_start); end
        total++; if (mdr_data !== 16'h0) begin bad++; $display("[TB] FAIL rst_data got=%0h exp=0", mdr_data); end
        total++; if (mdr_op !== 2'b00) begin bad++; $display("[TB] FAIL rst_op got=%0b exp=0", mdr_op); end
        total++; if (rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL rst_result got=%0h exp=0", rsp_result); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("[TB] FAIL rst_err got=%0b exp=0", rsp_err); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_req_ready got=%0b exp=1", req_ready); end
    endtask

    task automatic test_multiply();
        bit ok, got;
        model_mode = 0; model_result = 32'h6; model_rem = 32'h0; model_sign = 1'b1;
        send_request(2'b01, 16'h0003, 16'hFFFE, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL mul_accept got=0 exp=1"); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL mul_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        total++; if (load_cnt - base_load != 2) begin bad++; $display("[TB] FAIL mul_loads got=%0d exp=2", load_cnt - base_load); end
        total++; if (load_data[base_load % 64] !== 16'h0003) begin bad++; $display("[TB] FAIL mul_load0 got=%0h exp=0003", load_data[base_load % 64]); end
        total++; if (load_data[(base_load + 1) % 64] !== 16'hFFFE) begin bad++; $display("[TB] FAIL mul_load1 got=%0h exp=fffe", load_data[(base_load + 1) % 64]); end
        total++; if (start_cnt - base_start != 1) begin bad++; $display("[TB] FAIL mul_starts got=%0d exp=1", start_cnt - base_start); end
        total++; if (rsp_result !== 32'h6) begin bad++; $display("[TB] FAIL mul_result got=%0h exp=6", rsp_result); end
        total++; if (rsp_rem !== 32'h0) begin bad++; $display("[TB] FAIL mul_rem got=%0h exp=0", rsp_rem); end
        total++; if (rsp_sign !== 1'b1) begin bad++; $display("[TB] FAIL mul_sign got=%0b exp=1", rsp_sign); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("[TB] FAIL mul_err got=%0b exp=00", rsp_err); end
        total++; if (mdr_op !== 2'b01) begin bad++; $display("[TB] FAIL mul_mdr_op got=%0b exp=01", mdr_op); end
        consume();
    endtask

    task automatic test_divide();
        bit ok, got;
        model_mode = 0; model_result = 32'h3; model_rem = 32'h1; model_sign = 1'b0;
        send_request(2'b00, 16'd2, 16'd7, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL div_accept got=0 exp=1"); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL div_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        total++; if (start_cyc - acc_cyc != 5) begin bad++; $display("[TB] FAIL div_start_latency got=%0d exp=5", start_cyc - acc_cyc); end
        total++; if (load_data[base_load % 64] !== 16'd2) begin bad++; $display("[TB] FAIL div_load0 got=%0h exp=2", load_data[base_load % 64]); end
        total++; if (load_data[(base_load + 1) % 64] !== 16'd7) begin bad++; $display("[TB] FAIL div_load1 got=%0h exp=7", load_data[(base_load + 1) % 64]); end
        total++; if (rsp_result !== 32'h3) begin bad++; $display("[TB] FAIL div_result got=%0h exp=3", rsp_result); end
        total++; if (rsp_rem !== 32'h1) begin bad++; $display("[TB] FAIL div_rem got=%0h exp=1", rsp_rem); end
        total++; if (rsp_sign !== 1'b0) begin bad++; $display("[TB] FAIL div_sign got=%0b exp=0", rsp_sign); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("[TB] FAIL div_err got=%0b exp=00", rsp_err); end
        consume();
    endtask

    task automatic test_sqrt();
        bit ok, got;
        model_mode = 0; model_result = 32'h7; model_rem = 32'h1; model_sign = 1'b0;
        send_request(2'b10, 16'd50, 16'hBEEF, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL sqrt_accept got=0 exp=1"); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL sqrt_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        total++; if (load_cnt - base_load != 1) begin bad++; $display("[TB] FAIL sqrt_loads got=%0d exp=1", load_cnt - base_load); end
        total++; if (load_data[base_load % 64] !== 16'd50) begin bad++; $display("[TB] FAIL sqrt_load0 got=%0h exp=32", load_data[base_load % 64]); end
        total++; if (start_cyc - acc_cyc != 4) begin bad++; $display("[TB] FAIL sqrt_start_latency got=%0d exp=4", start_cyc - acc_cyc); end
        total++; if (rsp_result !== 32'h7) begin bad++; $display("[TB] FAIL sqrt_result got=%0h exp=7", rsp_result); end
        total++; if (rsp_rem !== 32'h1) begin bad++; $display("[TB] FAIL sqrt_rem got=%0h exp=1", rsp_rem); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("[TB] FAIL sqrt_err got=%0b exp=00", rsp_err); end
        consume();
    endtask

    task automatic test_illegal();
        bit ok;
        send_request(2'b11, 16'h1111, 16'h2222, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL ill_accept got=0 exp=1"); end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL ill_rsp_valid got=%0b exp=1", rsp_valid); end
        total++; if (rsp_err !== 2'b01) begin bad++; $display("[TB] FAIL ill_err got=%0b exp=01", rsp_err); end
        total++; if (rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL ill_result got=%0h exp=0", rsp_result); end
        total++; if (rsp_rem !== 32'h0) begin bad++; $display("[TB] FAIL ill_rem got=%0h exp=0", rsp_rem); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL ill_req_ready got=%0b exp=0", req_ready); end
        consume();
        total++; if (load_cnt - base_load != 0) begin bad++; $display("[TB] FAIL ill_loads got=%0d exp=0", load_cnt - base_load); end
        total++; if (start_cnt - base_start != 0) begin bad++; $display("[TB] FAIL ill_starts got=%0d exp=0", start_cnt - base_start); end
        total++; if (mdr_op !== 2'b10) begin bad++; $display("[TB] FAIL ill_mdr_op_kept got=%0b exp=10", mdr_op); end
    endtask

    task automatic test_stale_ready();
        bit ok, got;
        model_mode = 2; model_result = 32'h5; model_rem = 32'h2; model_sign = 1'b1;
        send_request(2'b00, 16'd3, 16'd17, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL stale_accept got=0 exp=1"); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL stale_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        total++; if (rsp_cyc - start_cyc != 5) begin bad++; $display("[TB] FAIL stale_blank_delay got=%0d exp=5", rsp_cyc - start_cyc); end
        total++; if (rsp_result !== 32'h5) begin bad++; $display("[TB] FAIL stale_result got=%0h exp=5", rsp_result); end
        total++; if (rsp_sign !== 1'b1) begin bad++; $display("[TB] FAIL stale_sign got=%0b exp=1", rsp_sign); end
        consume();
        model_mode = 0;
    endtask

    task automatic test_timeout();
        bit ok, got;
        model_mode = 1; model_result = 32'hAAAA_5555; model_rem = 32'h1234_5678; model_sign = 1'b1;
        send_request(2'b00, 16'd4, 16'd9, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL tmo_accept got=0 exp=1"); end
        wait_response(120, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL tmo_rsp_valid got=0 exp=1 (no response in 120 cycles)"); end
        total++; if (rsp_cyc - start_cyc != 67) begin bad++; $display("[TB] FAIL tmo_delay got=%0d exp=67", rsp_cyc - start_cyc); end
        total++; if (rsp_err !== 2'b10) begin bad++; $display("[TB] FAIL tmo_err got=%0b exp=10", rsp_err); end
        total++; if (rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL tmo_result got=%0h exp=0", rsp_result); end
        total++; if (rsp_rem !== 32'h0) begin bad++; $display("[TB] FAIL tmo_rem got=%0h exp=0", rsp_rem); end
        total++; if (rsp_sign !== 1'b0) begin bad++; $display("[TB] FAIL tmo_sign got=%0b exp=0", rsp_sign); end
        consume();
        model_mode = 0;
    endtask

    task automatic test_back_pressure();
        bit ok, got;
        int held_loads;
        model_mode = 0; model_result = 32'h9; model_rem = 32'h4; model_sign = 1'b0;
        send_request(2'b01, 16'd3, 16'd3, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp_accept got=0 exp=1"); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL bp_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        held_loads = load_cnt;
        // Queue the next request while the response is being held off
        req_valid = 1'b1; req_op = 2'b01; req_a = 16'h0005; req_b = 16'h0006;
        for (int i = 0; i < 10; i++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid_held[%0d] got=%0b exp=1", i, rsp_valid); end
            total++; if (rsp_result !== 32'h9 || rsp_rem !== 32'h4) begin bad++; $display("[TB] FAIL bp_payload[%0d] got=%0h/%0h exp=9/4", i, rsp_result, rsp_rem); end
            total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_req_ready[%0d] got=%0b exp=0", i, req_ready); end
            @(negedge clk);
        end
        model_result = 32'h1E; model_rem = 32'h0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_rsp_dropped got=%0b exp=0", rsp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_ready got=%0b exp=1", req_ready); end
        total++; if (load_cnt != held_loads) begin bad++; $display("[TB] FAIL b2b_no_early_load got=%0d exp=%0d", load_cnt, held_loads); end
        base_rise = rsp_rise_cnt;
        @(posedge clk);
        #2;
        acc_cyc = cyc - 1;
        req_valid = 1'b0;
        total++; if (mdr_loadctl !== 1'b1) begin bad++; $display("[TB] FAIL b2b_loadctl got=%0b exp=1", mdr_loadctl); end
        total++; if (mdr_data !== 16'h0005) begin bad++; $display("[TB] FAIL b2b_data got=%0h exp=0005", mdr_data); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy got=%0b exp=0", req_ready); end
        wait_response(40, got);
        total++; if (!got) begin bad++; $display("[TB] FAIL b2b_rsp_valid got=0 exp=1 (no response in 40 cycles)"); end
        total++; if (start_cyc - acc_cyc != 5) begin bad++; $display("[TB] FAIL b2b_start_latency got=%0d exp=5", start_cyc - acc_cyc); end
        total++; if (rsp_result !== 32'h1E) begin bad++; $display("[TB] FAIL b2b_result got=%0h exp=1e", rsp_result); end
        total++; if (overlap != 0) begin bad++; $display("[TB] FAIL strobe_overlap got=%0d exp=0", overlap); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        model_mode = 1;
        send_request(2'b01, 16'h00A5, 16'h005A, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rmid_accept got=0 exp=1"); end
        repeat (10) @(negedge clk);
        total++; if (mdr_data !== 16'h005A) begin bad++; $display("[TB] FAIL rmid_pre_data got=%0h exp=005a", mdr_data); end
        total++; if (mdr_op !== 2'b01) begin bad++; $display("[TB] FAIL rmid_pre_op got=%0b exp=01", mdr_op); end
        #3;
        reset = 1'b0;
        #1;
        total++; if (mdr_data !== 16'h0) begin bad++; $display("[TB] FAIL rmid_data got=%0h exp=0", mdr_data); end
        total++; if (mdr_op !== 2'b00) begin bad++; $display("[TB] FAIL rmid_op got=%0b exp=0", mdr_op); end
        total++; if (mdr_loadctl !== 1'b0 || mdr_start !== 1'b0) begin bad++; $display("[TB] FAIL rmid_strobes got=%0b%0b exp=00", mdr_loadctl, mdr_start); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (rsp_result !== 32'h0) begin bad++; $display("[TB] FAIL rmid_result got=%0h exp=0", rsp_result); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        total++; if (rsp_rise_cnt != base_rise) begin bad++; $display("[TB] FAIL rmid_no_rsp got=%0d exp=0", rsp_rise_cnt - base_rise); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_req_ready got=%0b exp=1", req_ready); end
        model_mode = 0;
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_sqrt();
        test_illegal();
        test_stale_ready();
        test_timeout();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation exceeded time limit");
    end

endmodule
